// File: rtl/rf_stage_pkg.sv
// Shared types and helpers for the register-read stage: widths, writeback port
// bundle, pipeline-register layout and the writeback forwarding resolver.
package rf_stage_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int WIDTH_UOP = 16;
    localparam int UOP_W     = WIDTH_UOP;
    localparam int EXP_W     = 6;
    localparam int RF_ADDR_W = 5;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO = '0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [XLEN-1:0]      xlen_t;

    typedef struct packed {
        logic     en;
        rf_addr_t addr;
        xlen_t    data;
    } wb_port_t;

    typedef struct packed {
        logic             eu0_en;
        logic [UOP_W-1:0] eu0_uop;
        rf_addr_t         eu0_rd;
        rf_addr_t         eu0_rj;
        rf_addr_t         eu0_rk;
        xlen_t            eu0_imm;
        xlen_t            eu0_pc;
        xlen_t            eu0_pc_next;
        logic [EXP_W-1:0] eu0_exp;
        logic             eu1_en;
        logic [UOP_W-1:0] eu1_uop;
        rf_addr_t         eu1_rd;
        rf_addr_t         eu1_rj;
        rf_addr_t         eu1_rk;
    } issue_t;

    // r0 reads as zero; otherwise a matching write wins over base, lane 1 over lane 0.
    function automatic xlen_t wb_resolve(rf_addr_t addr, xlen_t base,
                                         wb_port_t wb0, wb_port_t wb1);
        xlen_t r;
        r = base;
        if (addr == RF_ZERO)
            r = '0;
        else if (wb1.en && wb1.addr == addr)
            r = wb1.data;
        else if (wb0.en && wb0.addr == addr)
            r = wb0.data;
        return r;
    endfunction

endpackage

// File: rtl/rf_stage_regfile.sv
// 32x32 architectural register file: r0 hard-wired to zero, two write ports with
// lane-1 priority, four asynchronous read ports with write-through forwarding.
module rf_stage_regfile
    import rf_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  wb_port_t wb0,
    input  wb_port_t wb1,
    input  rf_addr_t raddr [4],
    output xlen_t    rdata [4]
);

    xlen_t mem_q [NREG];
    xlen_t mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (wb0.en && wb0.addr != RF_ZERO)
            mem_d[wb0.addr] = wb0.data;
        if (wb1.en && wb1.addr != RF_ZERO)
            mem_d[wb1.addr] = wb1.data;
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mem_q <= '{default: '0};
        else
            mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            rdata[i] = wb_resolve(raddr[i], mem_q[raddr[i]], wb0, wb1);
    end

endmodule

// File: rtl/rf_stage.sv
// Register-read stage: register file plus the issue->exe pipeline register, with
// held operands refreshed from writeback while the stage is stalled.
module rf_stage
    import rf_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             is_eu0_en,
    input  logic [UOP_W-1:0] is_eu0_uop,
    input  logic [4:0]       is_eu0_rd,
    input  logic [4:0]       is_eu0_rj,
    input  logic [4:0]       is_eu0_rk,
    input  logic [31:0]      is_eu0_imm,
    input  logic [31:0]      is_eu0_pc,
    input  logic [31:0]      is_eu0_pc_next,
    input  logic [5:0]       is_eu0_exp,
    input  logic             is_eu1_en,
    input  logic [UOP_W-1:0] is_eu1_uop,
    input  logic [4:0]       is_eu1_rd,
    input  logic [4:0]       is_eu1_rj,
    input  logic [4:0]       is_eu1_rk,
    input  logic             wb_en0,
    input  logic             wb_en1,
    input  logic [4:0]       wb_addr0,
    input  logic [4:0]       wb_addr1,
    input  logic [31:0]      wb_data0,
    input  logic [31:0]      wb_data1,
    output logic             eu0_en_in,
    output logic [UOP_W-1:0] eu0_uop_in,
    output logic [4:0]       eu0_rd_in,
    output logic [4:0]       eu0_rj_in,
    output logic [4:0]       eu0_rk_in,
    output logic [31:0]      eu0_imm_in,
    output logic [31:0]      eu0_pc_in,
    output logic [31:0]      eu0_pc_next_in,
    output logic [5:0]       eu0_exp_in,
    output logic             eu1_en_in,
    output logic [UOP_W-1:0] eu1_uop_in,
    output logic [4:0]       eu1_rd_in,
    output logic [4:0]       eu1_rj_in,
    output logic [4:0]       eu1_rk_in,
    output logic [31:0]      data00,
    output logic [31:0]      data01,
    output logic [31:0]      data10,
    output logic [31:0]      data11
);

    wb_port_t wb0, wb1;
    issue_t   issue;
    issue_t   pipe_q, pipe_d;
    xlen_t    opnd_q [4];
    xlen_t    opnd_d [4];
    rf_addr_t rd_addr [4];
    rf_addr_t held_addr [4];
    xlen_t    rd_data [4];

    assign wb0 = '{en: wb_en0, addr: wb_addr0, data: wb_data0};
    assign wb1 = '{en: wb_en1, addr: wb_addr1, data: wb_data1};

    assign issue = '{eu0_en: is_eu0_en, eu0_uop: is_eu0_uop, eu0_rd: is_eu0_rd,
                     eu0_rj: is_eu0_rj, eu0_rk: is_eu0_rk, eu0_imm: is_eu0_imm,
                     eu0_pc: is_eu0_pc, eu0_pc_next: is_eu0_pc_next,
                     eu0_exp: is_eu0_exp, eu1_en: is_eu1_en, eu1_uop: is_eu1_uop,
                     eu1_rd: is_eu1_rd, eu1_rj: is_eu1_rj, eu1_rk: is_eu1_rk};

    assign rd_addr   = '{is_eu0_rj, is_eu0_rk, is_eu1_rj, is_eu1_rk};
    assign held_addr = '{pipe_q.eu0_rj, pipe_q.eu0_rk, pipe_q.eu1_rj, pipe_q.eu1_rk};

    rf_stage_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .wb0   (wb0),
        .wb1   (wb1),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Flush only kills validity and exception; the rest of the payload is left as is.
    always_comb begin
        pipe_d = pipe_q;
        opnd_d = opnd_q;
        if (flush) begin
            pipe_d.eu0_en  = 1'b0;
            pipe_d.eu1_en  = 1'b0;
            pipe_d.eu0_exp = '0;
        end else if (stall) begin
            for (int i = 0; i < 4; i++)
                opnd_d[i] = wb_resolve(held_addr[i], opnd_q[i], wb0, wb1);
        end else begin
            pipe_d = issue;
            opnd_d = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
            opnd_q <= '{default: '0};
        end else begin
            pipe_q <= pipe_d;
            opnd_q <= opnd_d;
        end
    end

    assign eu0_en_in      = pipe_q.eu0_en;
    assign eu0_uop_in     = pipe_q.eu0_uop;
    assign eu0_rd_in      = pipe_q.eu0_rd;
    assign eu0_rj_in      = pipe_q.eu0_rj;
    assign eu0_rk_in      = pipe_q.eu0_rk;
    assign eu0_imm_in     = pipe_q.eu0_imm;
    assign eu0_pc_in      = pipe_q.eu0_pc;
    assign eu0_pc_next_in = pipe_q.eu0_pc_next;
    assign eu0_exp_in     = pipe_q.eu0_exp;
    assign eu1_en_in      = pipe_q.eu1_en;
    assign eu1_uop_in     = pipe_q.eu1_uop;
    assign eu1_rd_in      = pipe_q.eu1_rd;
    assign eu1_rj_in      = pipe_q.eu1_rj;
    assign eu1_rk_in      = pipe_q.eu1_rk;
    assign data00         = opnd_q[0];
    assign data01         = opnd_q[1];
    assign data10         = opnd_q[2];
    assign data11         = opnd_q[3];

endmodule
